// File: rtl/branch_predictor.sv
// Purpose: fetch-stage branch predictor built from a 2-bit counter BHT and a circular return-address stack.
// Latency: 1 cycle from fetch_valid to pred_valid; prediction outputs hold while fetch_valid is low.
// Backpressure: none; a prediction is issued for every fetch, and a BHT update is accepted every cycle.
module branch_predictor #(
    parameter int BHT_DEPTH = 256,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_inst,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        ras_flush,
    output logic        pred_valid,
    output logic        pred_is_branch,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int IDX_W  = $clog2(BHT_DEPTH);
    localparam int RAS_AW = $clog2(RAS_DEPTH);
    localparam logic [RAS_AW-1:0] PTR_ONE  = RAS_AW'(1);
    localparam logic [RAS_AW:0]   CNT_ONE  = (RAS_AW+1)'(1);
    localparam logic [RAS_AW:0]   CNT_FULL = (RAS_AW+1)'(RAS_DEPTH);

    logic [1:0]        bht [BHT_DEPTH];
    logic [31:0]       ras [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_top;
    logic [RAS_AW:0]   ras_cnt;

    // instruction fields
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] pc4;
    logic [31:0] push_addr;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;

    assign op        = fetch_inst[31:26];
    assign rs        = fetch_inst[25:21];
    assign rt        = fetch_inst[20:16];
    assign funct     = fetch_inst[5:0];
    assign imm       = fetch_inst[15:0];
    assign pc4       = fetch_pc + 32'd4;
    // return lands after the delay slot
    assign push_addr = pc4 + 32'd4;
    assign br_tgt    = pc4 + {{14{imm[15]}}, imm, 2'b00};
    assign j_tgt     = {pc4[31:28], fetch_inst[25:0], 2'b00};
    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign upd_idx   = upd_pc[IDX_W+1:2];

    // PC bits outside the BHT index never influence the counters
    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    logic is_regimm_br;
    logic is_link_br;
    logic is_cond;
    logic is_j;
    logic is_jal;
    logic is_jr;
    logic is_jalr;

    assign is_regimm_br = (op == 6'b000001) &&
                          (rt == 5'b00000 || rt == 5'b00001 || rt == 5'b10000 || rt == 5'b10001);
    assign is_link_br   = (op == 6'b000001) && (rt == 5'b10000 || rt == 5'b10001);
    assign is_cond      = (op[5:2] == 4'b0001) || is_regimm_br;
    assign is_j         = (op == 6'b000010);
    assign is_jal       = (op == 6'b000011);
    assign is_jr        = (op == 6'b000000) && (funct == 6'b001000);
    assign is_jalr      = (op == 6'b000000) && (funct == 6'b001001);

    logic        nxt_branch;
    logic        nxt_taken;
    logic [31:0] nxt_target;
    logic        do_push;
    logic        do_pop;

    // decode the fetched word into a prediction and the RAS action it implies
    always_comb begin
        nxt_branch = 1'b0;
        nxt_taken  = 1'b0;
        nxt_target = 32'd0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        if (is_cond) begin
            nxt_branch = 1'b1;
            nxt_taken  = bht[fetch_idx][1];
            nxt_target = bht[fetch_idx][1] ? br_tgt : 32'd0;
            do_push    = is_link_br;
        end else if (is_j || is_jal) begin
            nxt_branch = 1'b1;
            nxt_taken  = 1'b1;
            nxt_target = j_tgt;
            do_push    = is_jal;
        end else if (is_jr) begin
            nxt_branch = 1'b1;
            // only JR $31 is treated as a return; an empty stack gives no guess
            if (rs == 5'd31 && ras_cnt != '0) begin
                nxt_taken  = 1'b1;
                nxt_target = ras[ras_top];
                do_pop     = 1'b1;
            end
        end else if (is_jalr) begin
            nxt_branch = 1'b1;
            do_push    = 1'b1;
        end
    end

    // saturating 2-bit counter training from execute, independent of fetch
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!upd_taken && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
        end
    end

    // RAS pointer/count; flush wins over a same-cycle push or pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (ras_flush) begin
            ras_cnt <= '0;
        end else if (fetch_valid) begin
            if (do_push) begin
                ras_top <= ras_top + PTR_ONE;
                if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + CNT_ONE;
            end else if (do_pop) begin
                ras_top <= ras_top - PTR_ONE;
                ras_cnt <= ras_cnt - CNT_ONE;
            end
        end
    end

    // RAS storage; entries are only read below the count, so they need no reset
    always_ff @(posedge clk) begin
        if (fetch_valid && do_push && !ras_flush) ras[ras_top + PTR_ONE] <= push_addr;
    end

    // registered prediction outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pred_valid     <= 1'b0;
            pred_is_branch <= 1'b0;
            pred_taken     <= 1'b0;
            pred_target    <= 32'd0;
        end else begin
            pred_valid <= fetch_valid;
            if (fetch_valid) begin
                pred_is_branch <= nxt_branch;
                pred_taken     <= nxt_taken;
                pred_target    <= nxt_target;
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
Parameters:
REQ-001 SHALL provide parameter BHT_DEPTH, default 256, giving the number of 2-bit counters (power of 2, 4..4096); IDX_W = log2(BHT_DEPTH).
REQ-002 SHALL provide parameter RAS_DEPTH, default 8, giving the number of return-address entries (power of 2, 2..64).
Ports (name  direction  width  meaning):
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 fetch_valid  in  1  fetch_pc/fetch_inst valid this cycle.
REQ-006 fetch_pc  in  32  PC of the fetched instruction.
REQ-007 fetch_inst  in  32  fetched MIPS instruction word.
REQ-008 upd_valid  in  1  resolved conditional branch from execute.
REQ-009 upd_pc  in  32  PC of the resolved branch.
REQ-010 upd_taken  in  1  actual direction.
REQ-011 ras_flush  in  1  pipeline redirect; empties the return-address stack (RAS).
REQ-012 pred_valid  out  1  registered; prediction outputs valid.
REQ-013 pred_is_branch  out  1  instruction is a branch or jump.
REQ-014 pred_taken  out  1  predicted taken.
REQ-015 pred_target  out  32  predicted target; 0 when pred_taken=0.

Function
REQ-016 Latency SHALL be 1 cycle: outputs register fetch-cycle results; pred_valid = fetch_valid delayed by 1 cycle; other outputs hold when fetch_valid=0.
REQ-017 Decode: op=000010 J, 000011 JAL, 0001xx conditional, 000001 with rt in {00000,00001,10000,10001} conditional; op=000000 with funct 001000 JR, 001001 JALR; all else non-branch (is_branch=0, taken=0, target=0).
REQ-018 Arithmetic: pc4 = fetch_pc+4 (mod 2^32); branch target = pc4 + sign-extended imm16<<2 (mod 2^32); jump target = {pc4[31:28], inst[25:0], 2'b00}.
REQ-019 Conditional: taken = BHT[fetch_pc[IDX_W+1:2]][1]; target = branch target if taken.
REQ-020 J/JAL: taken=1, target = jump target.
REQ-021 JR with rs=31 and RAS non-empty: taken=1, target = RAS top; pop. With RAS empty: taken=0, target=0, no state change.
REQ-022 JR with rs!=31, and JALR: is_branch=1, taken=0, target=0.
REQ-023 Push pc4+4 (return address past the delay slot) on JAL, JALR, BLTZAL, BGEZAL when fetch_valid=1; pushes occur regardless of predicted direction.
REQ-024 RAS is circular: push writes at top+1 mod RAS_DEPTH; count saturates at RAS_DEPTH; a push when full overwrites the oldest entry.
REQ-025 Pop on empty SHALL leave pointer and count unchanged.
REQ-026 ras_flush SHALL set count to 0 and take priority over any same-cycle push or pop.
REQ-027 BHT update when upd_valid=1: index upd_pc[IDX_W+1:2]; saturating increment when upd_taken=1 (max 3), decrement otherwise (min 0).
REQ-028 Same-index fetch read and update in one cycle: the prediction SHALL use the pre-update counter.
REQ-029 State changes SHALL occur only when fetch_valid=1, except BHT updates, which are independent of fetch_valid.

Reset
REQ-030 When resetn=0, asynchronously: all BHT counters SHALL be 2'b01; RAS pointer and count SHALL be 0; pred_valid, pred_is_branch and pred_taken SHALL be 0; pred_target SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight predictions; the first pred_valid SHALL come 1 cycle after the first fetch_valid following reset release.

Verification
REQ-032 Reset; fetch BEQ imm=0x0004 at pc 0x00400000 -> next cycle pred_valid=1, is_branch=1, taken=0, target=0.
REQ-033 Apply upd_valid, upd_taken=1 twice at pc 0x00400000, then fetch the same BEQ -> taken=1, target=0x00400014; a third taken update plus four not-taken updates -> counter 0.
REQ-034 Fetch JAL 0x0C100040 at pc 0x00400100, then JR $31 (0x03E00008) -> JAL target 0x00400100 with push 0x00400108; JR taken=1, target 0x00400108; a second JR -> taken=0.
REQ-035 Push RAS_DEPTH+1 JALs at pcs 0x1000, 0x1010, ... then RAS_DEPTH+1 JR $31 -> returns in LIFO order; the oldest return is lost; the last JR is not taken.
REQ-036 Assert ras_flush in the same cycle as a JAL fetch -> RAS empty; a following JR $31 is not taken.
REQ-037 Assert resetn=0 in the cycle after a fetch -> pred_valid deasserts immediately (asynchronously) and the BHT returns to 01.
